// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory, with lock support.
// Optional build macro MEM_ADDR_CHECK_EN rejects misaligned or out-of-range (>256 words) accesses.
module data_memory_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_access_adr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] adr_q,    adr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              wen_q,    wen_d;
    logic              rd_q,     rd_d;
    logic              win_q,    win_d;
    logic              lkreq_q,  lkreq_d;
    logic              last_q,   last_d;
    logic              lkvld_q,  lkvld_d;
    logic              lkown_q,  lkown_d;
    logic              ack0_q,   ack0_d;
    logic              ack1_q,   ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef MEM_ADDR_CHECK_EN
    logic              err_q,    err_d;
    logic              sel_bad;
`endif

    logic              grant_vld;
    logic              grant_port;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // A valid lock pins the grant to its owner even while the owner is not requesting.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        if (lkvld_q) begin
            grant_port = lkown_q;
            grant_vld  = lkown_q ? req1 : req0;
        end else if (req0 && req1) begin
            grant_vld  = 1'b1;
            grant_port = ~last_q;
        end else if (req0 || req1) begin
            grant_vld  = 1'b1;
            grant_port = req1;
        end
    end

    assign sel_we    = grant_port ? we1    : we0;
    assign sel_lock  = grant_port ? lock1  : lock0;
    assign sel_addr  = grant_port ? addr1  : addr0;
    assign sel_wdata = grant_port ? wdata1 : wdata0;

`ifdef MEM_ADDR_CHECK_EN
    assign sel_bad = sel_addr[0] | (|sel_addr[ADDR_W-1:9]);
`endif

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        rd_d     = 1'b0;
        win_d    = win_q;
        lkreq_d  = lkreq_q;
        last_d   = last_q;
        lkvld_d  = lkvld_q;
        lkown_d  = lkown_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef MEM_ADDR_CHECK_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    win_d   = grant_port;
                    lkreq_d = sel_lock;
                    adr_d   = sel_addr;
                    wdata_d = sel_wdata;
`ifdef MEM_ADDR_CHECK_EN
                    if (sel_bad) begin
                        // Rejected accesses skip the memory cycle entirely.
                        state_d = RESP;
                        ack0_d  = ~grant_port;
                        ack1_d  = grant_port;
                        err_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = ISSUE;
                        wen_d   = sel_we;
                        rd_d    = ~sel_we;
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                if (rd_q) begin
                    if (win_q) rdata1_d = mem_read_data;
                    else       rdata0_d = mem_read_data;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = win_q;
                lkvld_d = lkreq_q;
                lkown_d = win_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            rd_q     <= 1'b0;
            win_q    <= 1'b0;
            lkreq_q  <= 1'b0;
            last_q   <= 1'b1;
            lkvld_q  <= 1'b0;
            lkown_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef MEM_ADDR_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            win_q    <= win_d;
            lkreq_q  <= lkreq_d;
            last_q   <= last_d;
            lkvld_q  <= lkvld_d;
            lkown_q  <= lkown_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef MEM_ADDR_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign mem_access_adr = adr_q;
    assign mem_write_data = wdata_q;
    assign mem_write_en   = wen_q;
    assign mem_read       = rd_q;
    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;

`ifdef MEM_ADDR_CHECK_EN
    assign err0 = err_q & ~win_q;
    assign err1 = err_q & win_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule
